// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I/RV64I decode stage.
// Contents:
//   - major opcode constants (instr[6:0])
//   - type_idx_e : bit position of each class inside the one-hot type vector
//   - imm_fmt_e  : immediate layout selector for imm_gen
//   - decoded_t  : one decoded instruction, used for the OUT and SKID registers
package decode_pkg;

  localparam int NUM_TYPES = 13;

  // pc and imm are stored at the widest supported XLEN; narrower
  // configurations use only the low XLEN bits.
  localparam int MAX_XLEN = 64;

  localparam logic [6:0] OPC_R       = 7'b0110011;
  localparam logic [6:0] OPC_I       = 7'b0010011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;

  typedef enum logic [3:0] {
    T_R, T_I, T_LOAD, T_STORE, T_BRANCH, T_JALR, T_JAL,
    T_LUI, T_AUIPC, T_FENCE, T_SYSTEM, T_OP32, T_OPIMM32
  } type_idx_e;

  typedef enum logic [2:0] {
    FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE
  } imm_fmt_e;

  typedef struct packed {
    logic [MAX_XLEN-1:0]  pc;
    logic [NUM_TYPES-1:0] typ;
    logic                 illegal;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [MAX_XLEN-1:0]  imm;
  } decoded_t;

endpackage

// File: rtl/instr_decode_stage_imm_gen.sv
// Immediate generator (purely combinational).
// Ports:
//   instr_i  : instruction bits 31:7 (the opcode never contributes to an immediate)
//   fmt_i    : immediate layout
//   imm_o    : immediate sign-extended from instr bit 31 to XLEN, 0 for FMT_NONE
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr_i,
  input  imm_fmt_e        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0]            imm32;
  logic signed [XLEN-1:0] imm_sext;

  always_comb begin
    imm32 = '0;
    case (fmt_i)
      FMT_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U:   imm32 = {instr_i[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    // Signed assignment widens to XLEN by replicating bit 31.
    imm_sext = $signed(imm32);
    imm_o    = imm_sext;
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered RV32I/RV64I decode stage with a 2-entry skid buffer.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   flush_i                 : drop held and incoming instructions
//   in_valid_i/in_ready_o   : fetch-side handshake; instr_i, pc_i
//   out_valid_o/out_ready_i : issue-side handshake
//   out_pc_o, type_o (one-hot), illegal_o, rd_o, rs1_o, rs2_o,
//   funct3_o, funct7_o, imm_o : decoded fields of the head instruction
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          instr_i,
  input  logic [XLEN-1:0]      pc_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [XLEN-1:0]      out_pc_o,
  output logic [NUM_TYPES-1:0] type_o,
  output logic                 illegal_o,
  output logic [4:0]           rd_o,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o,
  output logic [2:0]           funct3_o,
  output logic [6:0]           funct7_o,
  output logic [XLEN-1:0]      imm_o
);

  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_ONE   = 2'b01;
  localparam logic [1:0] S_TWO   = 2'b10;

  logic [1:0]           state_q, state_d;
  decoded_t             out_q, out_d;
  decoded_t             skid_q, skid_d;
  decoded_t             dec;
  logic [NUM_TYPES-1:0] type_vec;
  logic                 illegal;
  imm_fmt_e             fmt;
  logic [XLEN-1:0]      imm_x;
  logic                 in_fire;
  logic                 out_fire;

  // Class decode. Any illegal condition forces the class vector to zero and
  // the immediate format to NONE, so illegal instructions carry imm 0.
  always_comb begin
    type_vec = '0;
    illegal  = 1'b0;
    fmt      = FMT_NONE;
    case (instr_i[6:0])
      OPC_R:       type_vec[T_R] = 1'b1;
      OPC_I:       begin type_vec[T_I]      = 1'b1; fmt = FMT_I; end
      OPC_LOAD:    begin type_vec[T_LOAD]   = 1'b1; fmt = FMT_I; end
      OPC_STORE:   begin type_vec[T_STORE]  = 1'b1; fmt = FMT_S; end
      OPC_BRANCH:  begin type_vec[T_BRANCH] = 1'b1; fmt = FMT_B; end
      OPC_JALR: begin
        type_vec[T_JALR] = 1'b1;
        fmt              = FMT_I;
        illegal          = (instr_i[14:12] != 3'b000);
      end
      OPC_JAL:     begin type_vec[T_JAL]    = 1'b1; fmt = FMT_J; end
      OPC_LUI:     begin type_vec[T_LUI]    = 1'b1; fmt = FMT_U; end
      OPC_AUIPC:   begin type_vec[T_AUIPC]  = 1'b1; fmt = FMT_U; end
      OPC_FENCE:   begin type_vec[T_FENCE]  = 1'b1; fmt = FMT_I; end
      OPC_SYSTEM:  begin type_vec[T_SYSTEM] = 1'b1; fmt = FMT_I; end
      OPC_OP32: begin
        type_vec[T_OP32] = 1'b1;
        illegal          = (XLEN != 64);
      end
      OPC_OPIMM32: begin
        type_vec[T_OPIMM32] = 1'b1;
        fmt                 = FMT_I;
        illegal             = (XLEN != 64);
      end
      default:     illegal = 1'b1;
    endcase
    if (instr_i[1:0] != 2'b11) illegal = 1'b1;
    if (illegal) begin
      type_vec = '0;
      fmt      = FMT_NONE;
    end
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (instr_i[31:7]),
    .fmt_i   (fmt),
    .imm_o   (imm_x)
  );

  always_comb begin
    dec                = '0;
    dec.pc[XLEN-1:0]   = pc_i;
    dec.typ            = type_vec;
    dec.illegal        = illegal;
    dec.rd             = instr_i[11:7];
    dec.rs1            = instr_i[19:15];
    dec.rs2            = instr_i[24:20];
    dec.funct3         = instr_i[14:12];
    dec.funct7         = instr_i[31:25];
    dec.imm[XLEN-1:0]  = imm_x;
  end

  // in_ready depends only on the registered state (and reset), never on
  // out_ready_i, so there is no combinational path through the stage.
  assign in_ready_o  = (state_q != S_TWO) && !rst_i;
  assign out_valid_o = (state_q != S_EMPTY);
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;

  // Skid state machine. OUT always holds the oldest instruction; SKID only
  // fills when OUT is stalled, and drains into OUT when OUT is taken.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          state_d = S_ONE;
          out_d   = dec;
        end
      end
      S_ONE: begin
        if (out_fire && in_fire) begin
          out_d = dec;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end else if (in_fire) begin
          state_d = S_TWO;
          skid_d  = dec;
        end
      end
      S_TWO: begin
        if (out_fire) begin
          state_d = S_ONE;
          out_d   = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush_i) state_d = S_EMPTY;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign out_pc_o  = out_q.pc[XLEN-1:0];
  assign type_o    = out_q.typ;
  assign illegal_o = out_q.illegal;
  assign rd_o      = out_q.rd;
  assign rs1_o     = out_q.rs1;
  assign rs2_o     = out_q.rs2;
  assign funct3_o  = out_q.funct3;
  assign funct7_o  = out_q.funct7;
  assign imm_o     = out_q.imm[XLEN-1:0];

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered RV32I/RV64I instruction decode stage with a valid/ready handshake on both sides, parametrised on XLEN. Each accepted instruction becomes a one-hot instruction class, an illegal flag, register indices, funct fields and a sign-extended immediate. The block sits between fetch and the register-file read/issue stage. Its 2-entry skid buffer sustains one instruction per cycle under backpressure, and it supports pipeline flush.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. At 64, OP-32 and OP-IMM-32 decode as legal.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  drop all held and incoming instructions this cycle
- in_valid_i  in  1  fetch presents an instruction
- in_ready_o  out  1  stage can accept
- instr_i  in  32  raw instruction
- pc_i  in  XLEN  instruction address
- out_valid_o  out  1  decoded instruction available
- out_ready_i  in  1  downstream accepts
- out_pc_o  out  XLEN  PC of the decoded instruction
- type_o  out  NUM_TYPES (13)  one-hot class; all-zero when illegal
- illegal_o  out  1  instruction is not legal
- rd_o, rs1_o, rs2_o  out  5 each  register indices taken from bits 11:7, 19:15 and 24:20
- funct3_o  out  3  bits 14:12
- funct7_o  out  7  bits 31:25
- imm_o  out  XLEN  sign-extended immediate

## Operation
- A transfer occurs on a side when valid and ready are both high on a rising edge.
- Class is determined from opcode bits 6:0:
  - R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011
  - JALR 1100111, JAL 1101111, LUI 0110111, AUIPC 0010111
  - FENCE 0001111, SYSTEM 1110011
  - OP32 0111011 and OPIMM32 0011011, legal only when XLEN=64
- illegal_o=1 in any of these cases: instr[1:0]≠11, opcode not listed, a 64-bit-only opcode with XLEN=32, or JALR with funct3≠000. When illegal_o=1, type_o=0; the other fields are still passed through.
- Immediate formats, all sign-extended from bit 31 to XLEN:
  - I format: I, LOAD, JALR, OPIMM32, SYSTEM, FENCE
  - S format: STORE
  - B format: BRANCH, with bit0=0
  - U format: LUI, AUIPC, with low 12 bits = 0
  - J format: JAL, with bit0=0
  - R, OP32 and illegal instructions: imm_o=0
- Decode is combinational on instr_i. The result is registered into the output register (OUT) or the skid register (SKID).
- Skid state machine, tracking which registers are valid:
  - EMPTY: input accept → ONE.
  - ONE: output taken with no input → EMPTY. Output taken and input accepted → ONE (OUT reloaded). Output stalled and input accepted → TWO (input goes to SKID).
  - TWO: output taken → ONE (SKID moves to OUT). in_ready_o=0.
- in_ready_o = !skid_valid && !rst_i. It is a registered term, with no combinational path from out_ready_i.
- Output order always equals input order. No instruction is duplicated or dropped except by flush.
- Flush: both valid bits clear on the next edge (state → EMPTY). An input transfer in the same cycle is discarded. A flush overrides every other transition.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears with out_valid_o=1 after edge N.
- Throughput is 1 instruction per cycle with out_ready_i held high.
- Output fields are stable while out_valid_o=1 && out_ready_i=0.
- While rst_i=1 and after its deasserting edge:
  - out_valid_o=0, in_ready_o=0 during reset, and state=EMPTY
  - out_pc_o, type_o, illegal_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o and imm_o are all 0
  - in_ready_o=1 on the first cycle after reset
- Reset mid-stream discards OUT and SKID contents. Reset takes priority over flush.

## Structure
- Shared package decode_pkg contains:
  - opcode localparams
  - type index enum and NUM_TYPES=13
  - immediate-format enum (FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE)
  - packed struct decoded_t holding all output fields, used for both the OUT and SKID registers
- One sub-module, imm_gen, parametrised on XLEN: inputs instr and format, output imm. It is purely combinational.
- The class decode and the skid state machine stay in instr_decode_stage.

## Test plan
- addi x1,x0,-1 (0xFFF00093), XLEN=32 → one cycle later: type I, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF, illegal=0.
- Back-to-back instructions, out_ready_i=1:
  - sw x1,12(x2) (0x00112623) → STORE, rs1=2, rs2=1, imm=12.
  - beq x0,x0,-4 (0xFE000EE3) → BRANCH, imm=0xFFFFFFFC.
  - lui x5,0x12345 (0x123452B7) → LUI, imm=0x12345000.
  - One output per cycle.
- 0x00000000 and OP32 0x0020803B with XLEN=32 → illegal=1, type=0. The same OP32 instruction with XLEN=64 → OP32 class, illegal=0.
- Stream 4 instructions, holding out_ready_i=0 for 3 cycles:
  - Exactly 2 instructions are accepted and in_ready_o falls to 0.
  - After release, all 4 emerge in order with no loss or duplication.
- Stage in TWO, assert flush_i together with in_valid_i → next cycle out_valid_o=0, in_ready_o=1, and the flushed instructions never appear.
- Assert rst_i while in TWO → out_valid_o=0 and all outputs 0 after the edge, in_ready_o=1 the cycle after rst_i deasserts.
